// File: rtl/demux3_dispatch_if.sv
// ============================================================================
// Module : demux3_dispatch_if
// Brief  : Producer-side and consumer-side handshake bundle for demux3_dispatch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface demux3_dispatch_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic             out1_valid;
    logic             out2_valid;
    logic             out3_valid;
    logic             out1_ready;
    logic             out2_ready;
    logic             out3_ready;

    logic             sel_err;
    logic [7:0]       err_count;

    // master drives the producer side and the consumer readies (bench/system view)
    modport master (
        output in_data, in_sel, in_valid,
        output out1_ready, out2_ready, out3_ready,
        input  in_ready,
        input  out1_data, out2_data, out3_data,
        input  out1_valid, out2_valid, out3_valid,
        input  sel_err, err_count
    );

    modport slave (
        input  in_data, in_sel, in_valid,
        input  out1_ready, out2_ready, out3_ready,
        output in_ready,
        output out1_data, out2_data, out3_data,
        output out1_valid, out2_valid, out3_valid,
        output sel_err, err_count
    );
endinterface

`default_nettype wire

// File: rtl/demux3_dispatch.sv
// ============================================================================
// Module : demux3_dispatch
// Brief  : Routes one byte per cycle into one of three one-entry holding slots;
//          code 11 drops the byte and flags sel_err. Macro DEMUX3_ERR_COUNT_EN
//          enables the saturating illegal-code counter on err_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux3_dispatch #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    demux3_dispatch_if.slave   bus
);

    localparam logic c_EMPTY = 1'b0;
    localparam logic c_FULL  = 1'b1;

    logic [2:0]       w_out_ready;
    logic [2:0]       w_valid;
    logic [2:0]       w_slot_ready;
    logic [WIDTH-1:0] w_data [3];
    logic             w_legal;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_illegal_xfer;
    logic             r_sel_err;

    assign w_out_ready    = {bus.out3_ready, bus.out2_ready, bus.out1_ready};
    assign w_legal        = (bus.in_sel != 2'b11);
    assign w_accept       = bus.in_valid && w_in_ready;
    assign w_illegal_xfer = w_accept && !w_legal;

    // readiness depends only on the addressed slot, never on in_valid
    always_comb begin
        w_in_ready = 1'b1;
        case (bus.in_sel)
            2'b00:   w_in_ready = w_slot_ready[0];
            2'b01:   w_in_ready = w_slot_ready[1];
            2'b10:   w_in_ready = w_slot_ready[2];
            default: w_in_ready = 1'b1;
        endcase
    end

    assign bus.in_ready = w_in_ready;

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        logic             r_state;
        logic [WIDTH-1:0] r_data;
        logic             w_fill;
        logic             w_drain;

        assign w_fill  = w_accept && (bus.in_sel == 2'(gi));
        assign w_drain = (r_state == c_FULL) && w_out_ready[gi];

        // fill takes priority so a same-edge drain+fill keeps the slot full
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_EMPTY;
                r_data  <= '0;
            end else if (w_fill) begin
                r_state <= c_FULL;
                r_data  <= bus.in_data;
            end else if (w_drain) begin
                r_state <= c_EMPTY;
            end
        end

        assign w_valid[gi]      = (r_state == c_FULL);
        assign w_data[gi]       = r_data;
        assign w_slot_ready[gi] = (r_state == c_EMPTY) || w_out_ready[gi];
    end

    assign bus.out1_valid = w_valid[0];
    assign bus.out2_valid = w_valid[1];
    assign bus.out3_valid = w_valid[2];
    assign bus.out1_data  = w_data[0];
    assign bus.out2_data  = w_data[1];
    assign bus.out3_data  = w_data[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_illegal_xfer;
        end
    end

    assign bus.sel_err = r_sel_err;

`ifdef DEMUX3_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= 8'h00;
        end else if (w_illegal_xfer && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux3_dispatch.sv
// ============================================================================
// Module : tb_demux3_dispatch
// Brief  : Directed scoreboard bench for demux3_dispatch (per-slot byte queues).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux3_dispatch;

    logic clk;
    logic reset;

    demux3_dispatch_if #(.WIDTH(8)) bus ();

    demux3_dispatch #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb [3][$];
    logic       m_sel_err = 1'b0;
    logic [7:0] m_err = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic [2:0] ov;
        logic [7:0] od [3];
        ov    = {bus.out3_valid, bus.out2_valid, bus.out1_valid};
        od[0] = bus.out1_data;
        od[1] = bus.out2_data;
        od[2] = bus.out3_data;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out%0d_valid", k + 1), 32'(ov[k]), 32'(sb[k].size() != 0));
            if (sb[k].size() != 0)
                check($sformatf("out%0d_data", k + 1), 32'(od[k]), 32'(sb[k][0]));
        end
        check("sel_err", 32'(bus.sel_err), 32'(m_sel_err));
        check("err_count", 32'(bus.err_count), 32'(m_err));
    endtask

    // one clock of stimulus; called just after a falling edge
    task automatic cyc(input logic [7:0] d, input logic [1:0] s, input logic v, input logic [2:0] rdy);
        logic exp_rdy;
        int   si;
        bus.in_data    = d;
        bus.in_sel     = s;
        bus.in_valid   = v;
        bus.out1_ready = rdy[0];
        bus.out2_ready = rdy[1];
        bus.out3_ready = rdy[2];
        #1;
        si = int'(s);
        exp_rdy = (s == 2'b11) ? 1'b1 : ((sb[si].size() == 0) || rdy[si]);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check_outs();
        for (int k = 0; k < 3; k++)
            if (sb[k].size() != 0 && rdy[k]) void'(sb[k].pop_front());
        m_sel_err = v && exp_rdy && (s == 2'b11);
        if (v && exp_rdy) begin
            if (s == 2'b11) begin
`ifdef DEMUX3_ERR_COUNT_EN
                if (m_err != 8'hFF) m_err = m_err + 8'h01;
`endif
            end else begin
                sb[si].push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.in_data    = 8'($urandom);
            bus.in_sel     = 2'($urandom);
            bus.in_valid   = 1'($urandom);
            bus.out1_ready = 1'($urandom);
            bus.out2_ready = 1'($urandom);
            bus.out3_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) sb[k].delete();
        m_sel_err = 1'b0;
        m_err     = 8'h00;
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_data    = 8'h00;
        bus.in_sel     = 2'b00;
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        bus.out3_ready = 1'b0;
        @(negedge clk);

        // reset state
        do_reset(2);
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        bus.out3_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            check($sformatf("rst_in_ready_sel%0d", s), 32'(bus.in_ready), 32'd1);
        end
        check("rst_out1_data", 32'(bus.out1_data), 32'h00);
        check("rst_out2_data", 32'(bus.out2_data), 32'h00);
        check("rst_out3_data", 32'(bus.out3_data), 32'h00);
        check_outs();
        @(negedge clk);

        // basic routing
        cyc(8'hA5, 2'b00, 1'b1, 3'b111);
        cyc(8'h3C, 2'b01, 1'b1, 3'b111);
        cyc(8'hF0, 2'b10, 1'b1, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);

        // backpressure on out2, out1 traffic unaffected
        cyc(8'h11, 2'b01, 1'b1, 3'b101);
        cyc(8'h22, 2'b01, 1'b1, 3'b101);
        cyc(8'h33, 2'b00, 1'b1, 3'b101);
        cyc(8'h22, 2'b01, 1'b1, 3'b101);
        cyc(8'h22, 2'b01, 1'b1, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);

        // full throughput on out3
        for (int i = 1; i <= 8; i++) cyc(8'(i), 2'b10, 1'b1, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);

        // illegal code burst
        cyc(8'h5A, 2'b11, 1'b1, 3'b111);
        cyc(8'h5B, 2'b11, 1'b1, 3'b111);
        cyc(8'h5C, 2'b11, 1'b1, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);

        // saturation (macro build) then reset with a stalled full slot
        for (int i = 0; i < 260; i++) cyc(8'(i), 2'b11, 1'b1, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);
        cyc(8'h55, 2'b00, 1'b1, 3'b110);
        cyc(8'h66, 2'b00, 1'b1, 3'b110);
        do_reset(1);
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b0;
        #1;
        check("midrst_out1_valid", 32'(bus.out1_valid), 32'd0);
        check("midrst_err_count", 32'(bus.err_count), 32'h00);
        check_outs();
        @(negedge clk);
        cyc(8'h77, 2'b00, 1'b1, 3'b111);
        cyc(8'h00, 2'b00, 1'b0, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
